byte_fifo_reader: RTL and testbench

//  Drain side of the byte-packing FIFO: pulls a commanded frame of cmd_len bytes out of the byte window and emits it as

---
 rtl/byte_fifo_reader.sv | 135 +++++++++++++
 tb/tb_byte_fifo_reader.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module : byte_fifo_reader
// Drains commanded frames from the byte-packing FIFO window as valid/ready beats.
// Rev    : 1.0  initial release
// ============================================================================
module byte_fifo_reader #(
    parameter int DATA_BYTE_W = 16,
    parameter int TAKE_W      = 5,
    parameter int FIFO_CNT_W  = 6,
    parameter int LEN_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sync_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic [FIFO_CNT_W-1:0]      fifo_num_bytes,
    input  logic [DATA_BYTE_W*8-1:0]   fifo_data,
    output logic [TAKE_W-1:0]          fifo_take,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_BYTE_W*8-1:0]   m_data,
    output logic [TAKE_W-1:0]          m_bytes,
    output logic                       m_last,
    output logic                       done,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] c_beat_bytes = LEN_W'(DATA_BYTE_W);

    state_t                     r_state;
    logic [LEN_W-1:0]           r_remaining;
    logic                       r_m_valid;
    logic [DATA_BYTE_W*8-1:0]   r_m_data;
    logic [TAKE_W-1:0]          r_m_bytes;
    logic                       r_m_last;
    logic                       r_done;

    logic [LEN_W-1:0]           w_chunk;
    logic [LEN_W-1:0]           w_fifo_cnt;
    logic                       w_out_free;
    logic                       w_take_en;
    logic                       w_final_chunk;
    logic [DATA_BYTE_W*8-1:0]   w_masked;

    // Compare in a common zero-extended width so the occupancy check is unsigned.
    assign w_chunk       = (r_remaining > c_beat_bytes) ? c_beat_bytes : r_remaining;
    assign w_fifo_cnt    = LEN_W'(fifo_num_bytes);
    assign w_out_free    = ~r_m_valid | m_ready;
    assign w_take_en     = (r_state == ST_XFER) & w_out_free & ~sync_rst & (w_fifo_cnt >= w_chunk);
    assign w_final_chunk = (r_remaining == w_chunk);

    assign fifo_take = w_take_en ? w_chunk[TAKE_W-1:0] : '0;

    generate
        for (genvar gi = 0; gi < DATA_BYTE_W; gi++) begin : g_mask
            localparam logic [LEN_W-1:0] c_idx = LEN_W'(gi);
            assign w_masked[gi*8 +: 8] = (c_idx < w_chunk) ? fifo_data[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_bytes   <= '0;
            r_m_last    <= 1'b0;
            r_done      <= 1'b0;
        end else if (sync_rst) begin
            // Flush drops any beat in flight and suppresses the done pulse.
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= ST_XFER;
                            r_remaining <= cmd_len;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_take_en && w_final_chunk) begin
                        r_state <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    if (r_m_valid && m_ready && r_m_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A take in the same cycle as a handshake refills the register back-to-back.
            if (w_take_en) begin
                r_m_valid   <= 1'b1;
                r_m_data    <= w_masked;
                r_m_bytes   <= w_chunk[TAKE_W-1:0];
                r_m_last    <= w_final_chunk;
                r_remaining <= r_remaining - w_chunk;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE) & ~sync_rst;
    assign busy      = (r_state != ST_IDLE);
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_bytes   = r_m_bytes;
    assign m_last    = r_m_last;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_byte_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_byte_fifo_reader
// Bench for byte_fifo_reader: byte-queue FIFO model with frame scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_byte_fifo_reader;

    localparam int DBW      = 16;
    localparam int TAKE_W   = 5;
    localparam int CNT_W    = 6;
    localparam int LEN_W    = 16;
    localparam int FIFO_CAP = 63;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  sync_rst = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [LEN_W-1:0]      cmd_len = '0;
    logic [CNT_W-1:0]      fifo_num_bytes = '0;
    logic [DBW*8-1:0]      fifo_data = '0;
    logic [TAKE_W-1:0]     fifo_take;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [DBW*8-1:0]      m_data;
    logic [TAKE_W-1:0]     m_bytes;
    logic                  m_last;
    logic                  done;
    logic                  busy;

    byte_fifo_reader #(
        .DATA_BYTE_W (DBW),
        .TAKE_W      (TAKE_W),
        .FIFO_CNT_W  (CNT_W),
        .LEN_W       (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sync_rst       (sync_rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len        (cmd_len),
        .fifo_num_bytes (fifo_num_bytes),
        .fifo_data      (fifo_data),
        .fifo_take      (fifo_take),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_bytes        (m_bytes),
        .m_last         (m_last),
        .done           (done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    byte unsigned fifo_q[$];
    byte unsigned src_q[$];
    byte unsigned exp_q[$];
    int           take_log[$];
    int           take_left = 0;
    int           beat_left = 0;
    bit           busy_exp = 1'b0;
    bit           done_exp = 1'b0;
    int           fill_max = 0;
    int           ready_pct = 100;
    int           cyc = 0;
    int           done_at = -1;
    int           valid_cnt = 0;
    bit           last_m_valid = 1'b0;
    bit           stalled = 1'b0;
    logic [DBW*8-1:0]  stall_data = '0;
    logic [TAKE_W-1:0] stall_bytes = '0;
    logic              stall_last = 1'b0;

    task automatic check(input string tag, input logic [DBW*8-1:0] obs, input logic [DBW*8-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        fifo_q.delete();
        src_q.delete();
        exp_q.delete();
        take_left = 0;
        beat_left = 0;
        busy_exp  = 1'b0;
        done_exp  = 1'b0;
        stalled   = 1'b0;
    endtask

    // Move producer bytes into the FIFO, then present the window and drive m_ready.
    task automatic feed();
        int n;
        n = int'($urandom_range(0, fill_max));
        while (n > 0 && src_q.size() > 0 && fifo_q.size() < FIFO_CAP) begin
            fifo_q.push_back(src_q.pop_front());
            n--;
        end
        fifo_num_bytes = CNT_W'(fifo_q.size());
        for (int i = 0; i < DBW; i++)
            fifo_data[i*8 +: 8] = (i < fifo_q.size()) ? fifo_q[i] : 8'($urandom);
        m_ready = (int'($urandom_range(0, 99)) < ready_pct);
    endtask

    task automatic step();
        int               t;
        int               n;
        int               exp_take;
        bit               acc;
        bit               hs;
        bit               last_hs;
        logic [DBW*8-1:0] ed;
        feed();
        @(negedge clk);
        t            = int'(fifo_take);
        acc          = cmd_valid && cmd_ready;
        hs           = m_valid && m_ready;
        last_m_valid = m_valid;
        if (m_valid) valid_cnt++;
        check("cmd_ready", cmd_ready, !busy_exp && !sync_rst);
        check("busy", busy, busy_exp);
        check("done", done, done_exp);
        if (done) done_at = cyc;
        if (stalled) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, stall_data);
            check("hold_bytes", m_bytes, stall_bytes);
            check("hold_last", m_last, stall_last);
        end
        if (sync_rst) begin
            check("take_flush", t, 0);
        end else if (t != 0) begin
            exp_take = (take_left < DBW) ? take_left : DBW;
            check("take_size", t, exp_take);
            check("take_avail", (t <= int'(fifo_num_bytes)), 1);
            check("take_free", (!m_valid || m_ready), 1);
        end
        last_hs = 1'b0;
        if (hs) begin
            check("beat_expected", (beat_left > 0), 1);
            if (beat_left > 0) begin
                n  = (beat_left < DBW) ? beat_left : DBW;
                ed = '0;
                for (int i = 0; i < n; i++) ed[i*8 +: 8] = exp_q[i];
                check("beat_data", m_data, ed);
                check("beat_bytes", m_bytes, n);
                check("beat_last", m_last, (n == beat_left));
                last_hs = (n == beat_left);
                for (int i = 0; i < n; i++) void'(exp_q.pop_front());
                beat_left -= n;
            end
        end
        stalled     = m_valid && !m_ready && !sync_rst;
        stall_data  = m_data;
        stall_bytes = m_bytes;
        stall_last  = m_last;
        done_exp    = !sync_rst && ((acc && cmd_len == '0) || last_hs);
        take_log.push_back(t);
        @(posedge clk);
        #1;
        cyc++;
        if (sync_rst) begin
            model_flush();
        end else begin
            for (int i = 0; i < t && fifo_q.size() > 0; i++) void'(fifo_q.pop_front());
            take_left = (take_left > t) ? take_left - t : 0;
            if (acc && cmd_len != '0) busy_exp = 1'b1;
            if (last_hs) busy_exp = 1'b0;
        end
    endtask

    task automatic load_frame(input int len);
        byte unsigned b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            exp_q.push_back(b);
        end
        take_left = len;
        beat_left = len;
    endtask

    task automatic preload();
        while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
    endtask

    task automatic issue(input int len);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((busy_exp || done_exp) && k < budget) begin
            step();
            k++;
        end
        check("drain_timeout", (busy_exp || done_exp), 0);
    endtask

    function automatic int log_sum(input int lo, input int hi);
        int s;
        s = 0;
        for (int i = lo; i <= hi && i < take_log.size(); i++) s += take_log[i];
        return s;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int vstart;
        int len;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_bytes", m_bytes, 0);
        check("rst_m_last", m_last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_take", fifo_take, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 40-byte frame, FIFO already holding 48 bytes, downstream always ready
        model_flush();
        take_log.delete();
        ready_pct = 100;
        fill_max  = 0;
        load_frame(40);
        preload();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'($urandom));
        start = cyc;
        issue(40);
        drain(20);
        check("t1_take_idle", take_log[0], 0);
        check("t1_take_a", take_log[1], 16);
        check("t1_take_b", take_log[2], 16);
        check("t1_take_c", take_log[3], 8);
        check("t1_done_cycle", done_at - start, 5);

        // 16-byte frame waits for a full chunk: 10 bytes, then 16
        model_flush();
        take_log.delete();
        load_frame(16);
        for (int i = 0; i < 10; i++) fifo_q.push_back(src_q.pop_front());
        issue(16);
        repeat (3) step();
        check("t2_no_partial", log_sum(0, 3), 0);
        preload();
        drain(20);
        check("t2_take", take_log[4], 16);
        check("t2_take_total", log_sum(0, take_log.size() - 1), 16);

        // 48-byte frame with five backpressure cycles after beat 1
        model_flush();
        take_log.delete();
        load_frame(48);
        preload();
        start = cyc;
        issue(48);
        ready_pct = 0;
        repeat (6) step();
        ready_pct = 100;
        drain(20);
        check("t3_take_a", take_log[1], 16);
        check("t3_stall_takes", log_sum(2, 6), 0);
        check("t3_take_b", take_log[7], 16);
        check("t3_take_c", take_log[8], 16);
        check("t3_done_cycle", done_at - start, 10);

        // 5-byte frame out of an all-0xFF window: upper bytes must be zero
        model_flush();
        take_log.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'hFF);
        take_left = 5;
        beat_left = 5;
        start = cyc;
        issue(5);
        drain(20);
        check("t4_take", take_log[1], 5);
        check("t4_done_cycle", done_at - start, 3);

        // Synchronous flush after beat 1 of a 64-byte frame
        model_flush();
        take_log.delete();
        load_frame(64);
        preload();
        issue(64);
        step();
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        done_at = -1;
        step();
        check("t5_valid_after", last_m_valid, 0);
        repeat (3) step();
        check("t5_no_done", done_at, -1);

        // Zero-length command
        model_flush();
        take_log.delete();
        vstart = valid_cnt;
        start  = cyc;
        issue(0);
        drain(5);
        check("t6_done_cycle", done_at - start, 1);
        check("t6_no_take", log_sum(0, take_log.size() - 1), 0);
        check("t6_no_valid", valid_cnt - vstart, 0);

        // Asynchronous reset mid-frame
        model_flush();
        load_frame(64);
        preload();
        issue(64);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("t7_valid", m_valid, 0);
        check("t7_busy", busy, 0);
        check("t7_data", m_data, 0);
        check("t7_done", done, 0);
        model_flush();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomised frames, producer rate and downstream readiness
        for (int f = 0; f < 25; f++) begin
            model_flush();
            fill_max  = int'($urandom_range(1, 24));
            ready_pct = int'($urandom_range(30, 100));
            len       = int'($urandom_range(1, 90));
            load_frame(len);
            issue(len);
            drain(600);
            check("rnd_all_delivered", beat_left, 0);
            repeat (int'($urandom_range(0, 2))) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
